// File: rtl/gray_conv_arbiter.sv
// gray_conv_arbiter
//   Round-robin arbiter in front of a Gray-to-binary converter. In IDLE the
//   lowest requesting index at or after rr_ptr is granted. Its Gray word and
//   index are captured, converted in CONV, and held in DONE until the consumer
//   accepts. After the accept, rr_ptr moves to the slot after the served id.
//
//   Build option:
//     GRAY_CONV_SERIAL_EN  defined   : CONV resolves one bit per cycle, MSB first
//                                      (WIDTH cycles in CONV).
//                          undefined : CONV resolves every bit in a single cycle.
//
//   Ports:
//     clk        in   rising-edge clock
//     rst_n      in   asynchronous active-low reset
//     req_valid  in   per-requester request
//     req_gray   in   Gray words, requester i at [i*WIDTH +: WIDTH]
//     req_ready  out  one-hot grant in IDLE, zero elsewhere
//     out_valid  out  result available (DONE)
//     out_ready  in   consumer accept
//     out_binary out  converted word, zero when out_valid is low
//     out_id     out  owner of the result, zero when out_valid is low
//     busy       out  high outside IDLE
module gray_conv_arbiter #(
   parameter int unsigned WIDTH   = 4,
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned IDW     = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*WIDTH-1:0] req_gray,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_binary,
   output logic [IDW-1:0]           out_id,
   output logic                     busy
);

   typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

   state_e           state_q, state_d;
   logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IDW-1:0]   id_q, id_d;
   logic [WIDTH-1:0] gray_q, gray_d;
   logic [WIDTH-1:0] bin_q, bin_d;
   logic             out_valid_q, out_valid_d;

`ifdef GRAY_CONV_SERIAL_EN
   localparam int unsigned CW = $clog2(WIDTH);
   logic [CW-1:0]  cnt_q, cnt_d;
   // Bit WIDTH is a constant zero so the MSB step needs no special case.
   logic [WIDTH:0] bin_ext;
   assign bin_ext = {1'b0, bin_q};
`endif

   // Round-robin pick: scan from rr_ptr upward with wrap, first hit wins.
   logic                 gnt_any;
   logic [IDW-1:0]       gnt_id;
   logic [NUM_REQ-1:0]   gnt_oh;
   logic [WIDTH-1:0]     gnt_gray;

   always_comb begin
      int idx;
      idx      = 0;
      gnt_any  = 1'b0;
      gnt_id   = '0;
      gnt_oh   = '0;
      gnt_gray = '0;
      for (int off = 0; off < int'(NUM_REQ); off++) begin
         idx = int'(rr_ptr_q) + off;
         if (idx >= int'(NUM_REQ)) begin
            idx = idx - int'(NUM_REQ);
         end
         if (!gnt_any && req_valid[idx]) begin
            gnt_any     = 1'b1;
            gnt_id      = IDW'(idx);
            gnt_oh[idx] = 1'b1;
            gnt_gray    = req_gray[idx*int'(WIDTH) +: WIDTH];
         end
      end
   end

   // Gated by rst_n so req_ready stays low while reset is held.
   assign req_ready = (state_q == StIdle && rst_n) ? gnt_oh : '0;

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      id_d        = id_q;
      gray_d      = gray_q;
      bin_d       = bin_q;
      out_valid_d = out_valid_q;
`ifdef GRAY_CONV_SERIAL_EN
      cnt_d       = cnt_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (gnt_any) begin
               gray_d  = gnt_gray;
               id_d    = gnt_id;
               bin_d   = '0;
`ifdef GRAY_CONV_SERIAL_EN
               cnt_d   = CW'(WIDTH - 1);
`endif
               state_d = StConv;
            end
         end
         StConv: begin
`ifdef GRAY_CONV_SERIAL_EN
            bin_d[cnt_q] = gray_q[cnt_q] ^ bin_ext[int'(cnt_q) + 1];
            if (cnt_q == '0) begin
               state_d     = StDone;
               out_valid_d = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
`else
            bin_d[WIDTH-1] = gray_q[WIDTH-1];
            for (int k = int'(WIDTH) - 2; k >= 0; k--) begin
               bin_d[k] = bin_d[k+1] ^ gray_q[k];
            end
            state_d     = StDone;
            out_valid_d = 1'b1;
`endif
         end
         StDone: begin
            // Return to IDLE only; the next grant waits one cycle.
            if (out_ready) begin
               state_d     = StIdle;
               out_valid_d = 1'b0;
               rr_ptr_d    = (id_q == IDW'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         rr_ptr_q    <= '0;
         id_q        <= '0;
         gray_q      <= '0;
         bin_q       <= '0;
         out_valid_q <= 1'b0;
`ifdef GRAY_CONV_SERIAL_EN
         cnt_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         id_q        <= id_d;
         gray_q      <= gray_d;
         bin_q       <= bin_d;
         out_valid_q <= out_valid_d;
`ifdef GRAY_CONV_SERIAL_EN
         cnt_q       <= cnt_d;
`endif
      end
   end

   assign out_valid  = out_valid_q;
   assign out_binary = out_valid_q ? bin_q : '0;
   assign out_id     = out_valid_q ? id_q : '0;
   assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Bench for gray_conv_arbiter (WIDTH=4, NUM_REQ=4). Stimulus pushes the
// expected {id, binary} at each grant; a negedge monitor pops and compares
// on every output handshake.
module tb_gray_conv_arbiter;

   localparam int unsigned W = 4;
   localparam int unsigned N = 4;
`ifdef GRAY_CONV_SERIAL_EN
   localparam int LAT = W + 1;
`else
   localparam int LAT = 2;
`endif

   typedef struct packed {
      logic [1:0] id;
      logic [3:0] bin;
   } exp_t;

   logic           clk = 1'b0;
   logic           rst_n = 1'b1;
   logic [N-1:0]   req_valid = '0;
   logic [N*W-1:0] req_gray = '0;
   logic [N-1:0]   req_ready;
   logic           out_valid;
   logic           out_ready = 1'b1;
   logic [W-1:0]   out_binary;
   logic [1:0]     out_id;
   logic           busy;

   exp_t q[$];
   int   total = 0;
   int   bad = 0;

   gray_conv_arbiter #(
      .WIDTH   (W),
      .NUM_REQ (N)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_gray   (req_gray),
      .req_ready  (req_ready),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_binary (out_binary),
      .out_id     (out_id),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [3:0] g2b(input logic [3:0] g);
      logic [3:0] b;
      b[3] = g[3];
      b[2] = b[3] ^ g[2];
      b[1] = b[2] ^ g[1];
      b[0] = b[1] ^ g[0];
      return b;
   endfunction

   // Monitor: score every handshake, and zero-ness of outputs when idle.
   always @(negedge clk) begin
      if (out_valid && out_ready) begin
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_out: got id=%0d bin=%b expected none", out_id, out_binary);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("out_id", out_id, e.id);
            check("out_binary", out_binary, e.bin);
         end
      end else if (!out_valid) begin
         check("idle_zero", {out_id, out_binary}, 0);
      end
   end

   // Wait for a grant, check it is the expected one-hot, optionally score it.
   task automatic grant(input int id, input logic [3:0] bin, input bit push);
      int n;
      exp_t e;
      n = 0;
      #1;
      while (req_ready == '0 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check("grant_ready", req_ready, 1 << id);
      if (push) begin
         e.id  = id[1:0];
         e.bin = bin;
         q.push_back(e);
      end
      @(posedge clk); #1;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((busy || q.size() != 0) && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check("drain_busy", busy, 0);
      check("drain_queue", q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int lat;
      int n;

      // Reset state, with requests present to tempt req_ready.
      #1 rst_n = 1'b0;
      req_valid = 4'b1111;
      #2;
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_req_ready", req_ready, 0);
      check("rst_out_binary", out_binary, 0);
      check("rst_out_id", out_id, 0);
      @(posedge clk); @(posedge clk); #1;
      check("rst_req_ready_clk", req_ready, 0);
      req_valid = '0;
      rst_n = 1'b1;

      // Single request and latency.
      req_gray[3:0] = 4'b0110;
      req_valid = 4'b0001;
      grant(0, 4'b0100, 1);
      req_valid = '0;
      lat = 1;
      while (!out_valid && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      check("latency", lat, LAT);
      wait_idle();

      // All Gray codes on requester 3; leaves rr_ptr at 0.
      for (int g = 0; g < 16; g++) begin
         logic [3:0] gv;
         gv = 4'(g);
         req_gray[15:12] = gv;
         req_valid = 4'b1000;
         grant(3, g2b(gv), 1);
         req_valid = '0;
         wait_idle();
      end

      // Contention with all requesters held.
      req_gray = {4'b0001, 4'b1111, 4'b0000, 4'b1000};
      req_valid = 4'b1111;
      grant(0, 4'b1111, 1);
      grant(1, 4'b0000, 1);
      grant(2, 4'b1010, 1);
      grant(3, 4'b0001, 1);
      grant(0, 4'b1111, 1);
      req_valid = '0;
      wait_idle();

      // Round robin wrap: after id 2, requests 0 and 2 -> id 0.
      req_gray[11:8] = 4'b0101;
      req_valid = 4'b0100;
      grant(2, 4'b0110, 1);
      req_valid = '0;
      wait_idle();
      req_gray[3:0] = 4'b0010;
      req_valid = 4'b0101;
      grant(0, 4'b0011, 1);
      req_valid = '0;
      wait_idle();

      // Backpressure in DONE.
      out_ready = 1'b0;
      req_gray[7:4] = 4'b0011;
      req_valid = 4'b0010;
      grant(1, 4'b0010, 1);
      req_valid = '0;
      n = 0;
      while (!out_valid && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      req_valid = 4'b1111;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check("bp_out_valid", out_valid, 1);
         check("bp_out_binary", out_binary, 4'b0010);
         check("bp_out_id", out_id, 1);
         check("bp_req_ready", req_ready, 0);
      end
      req_valid = '0;
      out_ready = 1'b1;
      wait_idle();

      // Reset during CONV: aborted word never appears, next grant from id 0.
      req_gray[11:8] = 4'b1100;
      req_valid = 4'b0100;
      grant(2, 4'b0000, 0);
      req_valid = '0;
      rst_n = 1'b0;
      req_valid = 4'b1111;
      #1;
      check("abort_out_valid", out_valid, 0);
      check("abort_busy", busy, 0);
      check("abort_outputs", {out_id, out_binary}, 0);
      check("abort_req_ready", req_ready, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      req_gray[3:0] = 4'b1011;
      grant(0, 4'b1101, 1);
      req_valid = '0;
      wait_idle();

      @(posedge clk); #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
